// File: rtl/image_pipeline_sequencer.sv
// Stage sequencer for the image-processing top level.
// One start request walks the design through receive, pad, conv and
// transmit. An all-low gap sits between consecutive stages. The pad and
// conv stages are guarded by a watchdog that drops into an error state.
module image_pipeline_sequencer #(
  parameter int TX_CYCLES      = 142213120,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int GAP_CYCLES     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       imrxcomplete,
  input  logic       padded_complete,
  input  logic       conv_complete,
  output logic       recieve,
  output logic       pad,
  output logic       conv,
  output logic       transmit,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RECV = 3'd1,
    S_PAD  = 3'd2,
    S_CONV = 3'd3,
    S_TX   = 3'd4,
    S_GAP  = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  localparam logic [27:0] CNT_MAX = '1;
  localparam logic [27:0] TX_LIM  = TX_CYCLES[27:0];
  localparam logic [27:0] TO_LIM  = TIMEOUT_CYCLES[27:0];
  localparam logic [27:0] GAP_LIM = GAP_CYCLES[27:0];

  state_t      state_reg, state_next;
  state_t      gap_ret_reg, gap_ret_next;
  logic [27:0] cnt_reg;
  logic [27:0] elapsed;
  logic        start_reg, start_prev_reg;
  logic        start_evt;
  logic        flag_ok;

  logic        recieve_reg, pad_reg, conv_reg, transmit_reg;
  logic        busy_reg, done_reg, error_reg;
  logic [2:0]  state_out_reg;

  // cnt_reg holds the cycles already spent in the current state, so
  // elapsed counts the current cycle too. It saturates rather than wraps.
  assign elapsed   = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 28'd1;
  assign start_evt = start_reg & ~start_prev_reg;
  // Flags seen in the first cycle of a stage may be left over from the
  // previous stage, so they are not honoured until the second cycle.
  assign flag_ok   = (elapsed >= 28'd2);

  // Register start and keep one cycle of history for rise detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_reg      <= 1'b0;
      start_prev_reg <= 1'b0;
    end else begin
      start_reg      <= start;
      start_prev_reg <= start_reg;
    end
  end

  // State, gap return target and stage counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      gap_ret_reg <= S_IDLE;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      gap_ret_reg <= gap_ret_next;
      if (state_next != state_reg)
        cnt_reg <= '0;
      else
        cnt_reg <= elapsed;
    end
  end

  // Next-state selection. Abort overrides every other transition.
  always_comb begin
    state_next   = state_reg;
    gap_ret_next = gap_ret_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_evt) state_next = S_RECV;
      end
      S_RECV: begin
        if (flag_ok && imrxcomplete) begin
          state_next   = S_GAP;
          gap_ret_next = S_PAD;
        end
      end
      S_PAD: begin
        if (flag_ok && padded_complete) begin
          state_next   = S_GAP;
          gap_ret_next = S_CONV;
        end else if (elapsed >= TO_LIM) begin
          state_next = S_ERR;
        end
      end
      S_CONV: begin
        if (flag_ok && conv_complete) begin
          state_next   = S_GAP;
          gap_ret_next = S_TX;
        end else if (elapsed >= TO_LIM) begin
          state_next = S_ERR;
        end
      end
      S_TX: begin
        if (elapsed >= TX_LIM) begin
          state_next   = S_GAP;
          gap_ret_next = S_DONE;
        end
      end
      S_GAP: begin
        if (elapsed >= GAP_LIM) state_next = gap_ret_reg;
      end
      default: state_next = S_IDLE;
    endcase
    if (abort && (state_reg != S_IDLE)) state_next = S_IDLE;
  end

  // Outputs are registered decodes of the upcoming state, so they line up with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      recieve_reg   <= 1'b0;
      pad_reg       <= 1'b0;
      conv_reg      <= 1'b0;
      transmit_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
      state_out_reg <= 3'd0;
    end else begin
      recieve_reg   <= (state_next == S_RECV);
      pad_reg       <= (state_next == S_PAD);
      conv_reg      <= (state_next == S_CONV);
      transmit_reg  <= (state_next == S_TX);
      busy_reg      <= (state_next == S_RECV) || (state_next == S_PAD) ||
                       (state_next == S_CONV) || (state_next == S_TX)  ||
                       (state_next == S_GAP);
      done_reg      <= (state_next == S_DONE);
      error_reg     <= (state_next == S_ERR);
      state_out_reg <= state_next;
    end
  end

  assign recieve  = recieve_reg;
  assign pad      = pad_reg;
  assign conv     = conv_reg;
  assign transmit = transmit_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign error    = error_reg;
  assign state    = state_out_reg;

endmodule

// File: tb/tb_image_pipeline_sequencer.sv
// Self-checking bench for image_pipeline_sequencer with short timing parameters.
module tb_image_pipeline_sequencer;

  localparam int TXC  = 20;
  localparam int TOC  = 50;
  localparam int GAPC = 3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RECV = 3'd1;
  localparam logic [2:0] ST_PAD  = 3'd2;
  localparam logic [2:0] ST_CONV = 3'd3;
  localparam logic [2:0] ST_TX   = 3'd4;
  localparam logic [2:0] ST_GAP  = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;
  localparam logic [2:0] ST_ERR  = 3'd7;

  logic       clk = 1'b0;
  logic       reset, start, abort, imrx, padc, convc;
  logic       recieve, pad, conv, transmit, busy, done, error;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  image_pipeline_sequencer #(
    .TX_CYCLES(TXC), .TIMEOUT_CYCLES(TOC), .GAP_CYCLES(GAPC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .imrxcomplete(imrx), .padded_complete(padc), .conv_complete(convc),
    .recieve(recieve), .pad(pad), .conv(conv), .transmit(transmit),
    .busy(busy), .done(done), .error(error), .state(state)
  );

  always #5 clk = ~clk;

  // Per-cycle vectors: inputs applied before an edge, outputs expected after it.
  typedef struct packed {
    logic       start;
    logic       abort;
    logic       imrx;
    logic       padc;
    logic       convc;
    logic [2:0] st;
    logic [3:0] ctrl;   // {recieve, pad, conv, transmit}
    logic       busy;
  } vec_t;
  vec_t vecs[$];

  // Scoreboard of expected state segments {state, length}; length -1 = any.
  typedef struct {
    logic [2:0] st;
    int         len;
  } seg_t;
  seg_t exp_q[$];

  logic       mon_en = 1'b0;
  logic [2:0] mon_st = 3'd0;
  int         mon_len = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Segment monitor: on every state change compare the finished segment.
  always @(negedge clk) begin
    if (!mon_en) begin
      mon_st  = state;
      mon_len = 0;
    end else begin
      checks++;
      if ($countones({recieve, pad, conv, transmit}) > 1 ||
          (state == ST_GAP && {recieve, pad, conv, transmit} != 4'b0000)) begin
        failures++;
        $display("FAIL controls: got %b in state %0d", {recieve, pad, conv, transmit}, state);
      end
      if (state == mon_st) begin
        mon_len++;
      end else begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL segment: got state %0d len %0d, expected none", mon_st, mon_len);
        end else begin
          seg_t e;
          e = exp_q.pop_front();
          if (e.st != mon_st || (e.len >= 0 && e.len != mon_len)) begin
            failures++;
            $display("FAIL segment: got state %0d len %0d, expected state %0d len %0d",
                     mon_st, mon_len, e.st, e.len);
          end else begin
            $display("segment state=%0d len=%0d ok", mon_st, mon_len);
          end
        end
        mon_st  = state;
        mon_len = 1;
      end
    end
  end

  task automatic set_flag(input int idx, input logic v);
    case (idx)
      0: imrx  = v;
      1: padc  = v;
      default: convc = v;
    endcase
  endtask

  // Advance on negedges until state == s; an expired budget counts as a failure.
  task automatic wait_state(input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (state != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state != s) begin
      failures++;
      $display("FAIL wait_state: got state %0d expected %0d", state, s);
    end
  endtask

  // Wait for stage s, raise its flag 'delay' cycles in, drop it once the stage ends.
  task automatic do_stage(input logic [2:0] s, input int idx, input int delay);
    int n;
    wait_state(s, 200);
    repeat (delay) @(negedge clk);
    set_flag(idx, 1'b1);
    n = 0;
    while (state == s && n < 200) begin
      @(negedge clk);
      n++;
    end
    set_flag(idx, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; imrx = 1'b0; padc = 1'b0; convc = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_ctrl", {recieve, pad, conv, transmit}, 0);
    chk("reset_status", {busy, done, error}, 0);
    reset = 1'b0;
    @(negedge clk);

    // ---------------- table: start detect, stale flags, abort in TX
    vecs.push_back(vec_t'({5'b00000, ST_IDLE, 4'b0000, 1'b0}));
    vecs.push_back(vec_t'({5'b10000, ST_IDLE, 4'b0000, 1'b0}));
    vecs.push_back(vec_t'({5'b10000, ST_RECV, 4'b1000, 1'b1}));
    vecs.push_back(vec_t'({5'b10100, ST_RECV, 4'b1000, 1'b1}));
    vecs.push_back(vec_t'({5'b10100, ST_GAP,  4'b0000, 1'b1}));
    vecs.push_back(vec_t'({5'b10100, ST_GAP,  4'b0000, 1'b1}));
    vecs.push_back(vec_t'({5'b10100, ST_GAP,  4'b0000, 1'b1}));
    vecs.push_back(vec_t'({5'b10110, ST_PAD,  4'b0100, 1'b1}));
    vecs.push_back(vec_t'({5'b10110, ST_PAD,  4'b0100, 1'b1}));
    vecs.push_back(vec_t'({5'b00010, ST_GAP,  4'b0000, 1'b1}));
    vecs.push_back(vec_t'({5'b00000, ST_GAP,  4'b0000, 1'b1}));
    vecs.push_back(vec_t'({5'b00000, ST_GAP,  4'b0000, 1'b1}));
    vecs.push_back(vec_t'({5'b00001, ST_CONV, 4'b0010, 1'b1}));
    vecs.push_back(vec_t'({5'b00001, ST_CONV, 4'b0010, 1'b1}));
    vecs.push_back(vec_t'({5'b00001, ST_GAP,  4'b0000, 1'b1}));
    vecs.push_back(vec_t'({5'b00000, ST_GAP,  4'b0000, 1'b1}));
    vecs.push_back(vec_t'({5'b00000, ST_GAP,  4'b0000, 1'b1}));
    vecs.push_back(vec_t'({5'b00000, ST_TX,   4'b0001, 1'b1}));
    vecs.push_back(vec_t'({5'b01000, ST_IDLE, 4'b0000, 1'b0}));
    for (int i = 0; i < vecs.size(); i++) begin
      {start, abort, imrx, padc, convc} = {vecs[i].start, vecs[i].abort, vecs[i].imrx,
                                           vecs[i].padc, vecs[i].convc};
      @(negedge clk);
      $display("vec %0d state=%0d ctrl=%b busy=%0d", i, state,
               {recieve, pad, conv, transmit}, busy);
      chk($sformatf("vec%0d_state", i), state, vecs[i].st);
      chk($sformatf("vec%0d_ctrl", i), {recieve, pad, conv, transmit}, vecs[i].ctrl);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
    end
    {start, abort, imrx, padc, convc} = 5'b0;
    repeat (2) @(negedge clk);

    // ---------------- full run with start held high, scoreboarded segments
    exp_q.push_back('{ST_IDLE, -1});
    exp_q.push_back('{ST_RECV, 11});
    exp_q.push_back('{ST_GAP, GAPC});
    exp_q.push_back('{ST_PAD, 11});
    exp_q.push_back('{ST_GAP, GAPC});
    exp_q.push_back('{ST_CONV, 11});
    exp_q.push_back('{ST_GAP, GAPC});
    exp_q.push_back('{ST_TX, TXC});
    exp_q.push_back('{ST_GAP, GAPC});
    exp_q.push_back('{ST_DONE, -1});
    exp_q.push_back('{ST_RECV, 1});
    mon_en = 1'b1;
    start = 1'b1;
    do_stage(ST_RECV, 0, 10);
    do_stage(ST_PAD, 1, 10);
    do_stage(ST_CONV, 2, 10);
    wait_state(ST_DONE, 100);
    chk("done_flag", done, 1);
    chk("done_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("start_held_no_restart", state, ST_DONE);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("restart_state", state, ST_RECV);
    chk("restart_recieve", recieve, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    mon_en = 1'b0;

    // ---------------- watchdog on CONV
    start = 1'b1;
    wait_state(ST_RECV, 10);
    start = 1'b0;
    do_stage(ST_RECV, 0, 2);
    do_stage(ST_PAD, 1, 2);
    wait_state(ST_CONV, 20);
    begin
      int n;
      n = 0;
      while (state == ST_CONV && n < 200) begin
        @(negedge clk);
        n++;
      end
      $display("watchdog fired after %0d cycles", n);
      chk("watchdog_cycles", n, TOC);
    end
    chk("err_state", state, ST_ERR);
    chk("err_flag", error, 1);
    chk("err_ctrl", {recieve, pad, conv, transmit}, 0);
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("err_restart", state, ST_RECV);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);

    // ---------------- abort at TX cycle 7 with a coincident start rise
    start = 1'b1;
    wait_state(ST_RECV, 10);
    start = 1'b0;
    do_stage(ST_RECV, 0, 1);
    do_stage(ST_PAD, 1, 1);
    do_stage(ST_CONV, 2, 1);
    wait_state(ST_TX, 20);
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("tx_cycle7_transmit", transmit, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    $display("abort in TX: state=%0d transmit=%0d", state, transmit);
    chk("abort_transmit", transmit, 0);
    chk("abort_state", state, ST_IDLE);
    repeat (3) @(negedge clk);
    chk("abort_start_ignored", state, ST_IDLE);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // ---------------- asynchronous reset while in PAD
    start = 1'b1;
    wait_state(ST_RECV, 10);
    start = 1'b0;
    do_stage(ST_RECV, 0, 1);
    wait_state(ST_PAD, 20);
    chk("pre_reset_pad", pad, 1);
    #2 reset = 1'b1;
    #1;
    $display("async reset: state=%0d ctrl=%b", state, {recieve, pad, conv, transmit});
    chk("async_state", state, 0);
    chk("async_ctrl", {recieve, pad, conv, transmit}, 0);
    chk("async_status", {busy, done, error}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", state, ST_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/image_pipeline_sequencer.md
# image_pipeline_sequencer

Top-level stage sequencer that drives the level-sensitive `recieve`, `pad`, `conv` and `transmit` controls of the image-processing top module from a single start request. It advances stage to stage on the completion flags `imrxcomplete`, `padded_complete` and `conv_complete`. Between stages it inserts an all-low gap so each stage's level-derived reset is honoured. It also times the UART transmit phase, guards the pad and conv stages with a watchdog, and reports busy/done/error status.

## Interface
- `TX_CYCLES`, default 142213120: clock cycles `transmit` is held high (16384 bytes × 10 bits × 868 clk/bit).
- `TIMEOUT_CYCLES`, default 1000000: watchdog limit for the PAD and CONV stages.
- `GAP_CYCLES`, default 4: all-controls-low cycles between stages; legal range 1..255.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  run request; acted on at its rising edge only.
- `abort`  in  1  synchronous level; returns to IDLE.
- `imrxcomplete`  in  1  receive-stage completion flag.
- `padded_complete`  in  1  pad-stage completion flag.
- `conv_complete`  in  1  conv-stage completion flag.
- `recieve`  out  1  receive-stage enable (level).
- `pad`  out  1  pad-stage enable (level).
- `conv`  out  1  conv-stage enable (level).
- `transmit`  out  1  transmit-stage enable (level).
- `busy`  out  1  high in RECV, PAD, CONV, TX, GAP.
- `done`  out  1  high in DONE.
- `error`  out  1  high in ERR.
- `state`  out  3  current state code.

## Operation
- State codes: IDLE=0, RECV=1, PAD=2, CONV=3, TX=4, GAP=5, DONE=6, ERR=7.
- All outputs are registered and decoded from the state register only. At most one of `recieve`/`pad`/`conv`/`transmit` is high in any cycle.
- Reset values: all outputs 0, `state`=0.
- Start detection: `start` is registered, and a rise (prev 0, now 1) is a start event. A start event is accepted in IDLE, DONE or ERR and moves to RECV. It is ignored in every other state.
- `abort` high in any state except IDLE: next state is IDLE, and the stage counter and watchdog clear. When `abort` and a start event coincide, `abort` wins.
- Stage counter: clears on entry to each stage and saturates.
- Completion flags are accepted only once the stage counter ≥ 2. This rejects flags left stale from the previous stage.
- RECV: `recieve`=1. An accepted `imrxcomplete` moves to GAP with next=PAD. RECV has no watchdog.
- PAD: `pad`=1. An accepted `padded_complete` moves to GAP with next=CONV.
- CONV: `conv`=1. An accepted `conv_complete` moves to GAP with next=TX.
- PAD/CONV watchdog: when the stage counter reaches `TIMEOUT_CYCLES` without an accepted flag, move to ERR. If the flag is accepted in the same cycle the limit is reached, the flag wins.
- TX: `transmit`=1 for exactly `TX_CYCLES` cycles, then GAP with next=DONE. Completion inputs are ignored.
- GAP: all stage controls 0 for exactly `GAP_CYCLES` cycles, then enter the stored next state.
- DONE/ERR: hold until a start event, `abort` or `reset`.
- Counters are 28 bits wide. Parameters must fit in 28 bits.

## Timing
- Start rise sampled at edge n: `state`=1 and `recieve`=1 after edge n+1. This includes one cycle for the start register.
- Accepted flag at edge k: stage output falls after edge k. The next stage output rises after edge k+`GAP_CYCLES`.
- TX entered at edge t: `transmit` is high for edges t..t+`TX_CYCLES`−1 and falls after edge t+`TX_CYCLES`.
- `abort` sampled at edge a: all controls are low after edge a.
- `reset` asserted mid-operation: outputs clear immediately, independent of `clk`. The sequencer needs a fresh start rise after release.

## Test plan
Bench parameters: TX_CYCLES=20, TIMEOUT_CYCLES=50, GAP_CYCLES=3.
- Full run: start pulse, each flag raised 10 cycles into its stage → order RECV, GAP, PAD, GAP, CONV, GAP, TX (exactly 20 cycles), GAP, DONE. `done`=1, never two controls high at once, 3-cycle gaps observed.
- Stale flag: `imrxcomplete` held high on entering PAD with `padded_complete` high from cycle 0 → PAD lasts exactly 2 cycles, not 0.
- Watchdog: `conv_complete` never asserted → `error`=1, `state`=7 exactly 50 cycles after CONV entry. Then a start rise → RECV.
- Abort mid-TX at cycle 7 of TX, with a simultaneous start rise → `transmit` low next cycle, `state`=0, start ignored.
- Start held high continuously through DONE → no restart. A second restart requires a fall and a new rise.
- Async `reset` pulse between clock edges in PAD → all outputs 0 before the next edge, `state`=0.
